// File: rtl/draw_sequencer.sv
// Frame-synchronised draw scheduler.
// For each pass it optionally clears the framebuffer to a background colour.
// It then walks line_id over LINE_CNT geometry entries and handshakes every line with an
// external rasteriser (draw_start / draw_done).
// While the sequencer is idle or finished, the framebuffer port belongs to display scan.
module draw_sequencer #(
   parameter int unsigned XY_BITW       = 16,
   parameter int unsigned LINE_CNT      = 12,
   parameter int unsigned COLORW        = 3,
   parameter int unsigned FB_WIDTH      = 16,
   parameter int unsigned FB_HEIGHT     = 16,
   parameter int unsigned CLEAR_EN      = 1,
   parameter int unsigned BG_COLOR      = 0,
   parameter int unsigned GEOM_LAT      = 1,
   parameter int unsigned REDRAW_FRAMES = 1,
   localparam int unsigned LINEW        = (LINE_CNT > 1) ? $clog2(LINE_CNT) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               mode,
   input  logic               frame,
   output logic [LINEW-1:0]   line_id,
   input  logic [COLORW-1:0]  line_color,
   output logic               draw_start,
   input  logic               drawing,
   input  logic               draw_done,
   input  logic [XY_BITW-1:0] dl_x,
   input  logic [XY_BITW-1:0] dl_y,
   input  logic [XY_BITW-1:0] sx,
   input  logic [XY_BITW-1:0] sy,
   output logic               fb_we,
   output logic [XY_BITW-1:0] fb_x,
   output logic [XY_BITW-1:0] fb_y,
   output logic [COLORW-1:0]  fb_color,
   output logic               busy,
   output logic               done
);

   localparam int unsigned CXW  = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
   localparam int unsigned CYW  = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
   localparam int unsigned FCW  = (REDRAW_FRAMES > 1) ? $clog2(REDRAW_FRAMES) : 1;
   localparam int unsigned LATW = 2;

   localparam logic [CXW-1:0]    CX_LAST   = CXW'(FB_WIDTH - 1);
   localparam logic [CYW-1:0]    CY_LAST   = CYW'(FB_HEIGHT - 1);
   localparam logic [FCW-1:0]    FC_LAST   = FCW'(REDRAW_FRAMES - 1);
   localparam logic [LATW-1:0]   LAT_LAST  = LATW'(GEOM_LAT);
   localparam logic [LINEW-1:0]  LINE_LAST = LINEW'(LINE_CNT - 1);
   localparam logic [COLORW-1:0] BG        = COLORW'(BG_COLOR);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StInit,
      StDraw,
      StDone
   } state_e;

   state_e           state_q;
   logic [LINEW-1:0] line_id_q;
   logic             draw_start_q;
   logic [CXW-1:0]   cx_q;
   logic [CYW-1:0]   cy_q;
   logic [FCW-1:0]   frame_cnt_q;
   logic [LATW-1:0]  lat_cnt_q;

   // Where a pass begins: clear pass first when enabled, otherwise straight to geometry.
   state_e start_state;
   assign start_state = (CLEAR_EN != 0) ? StClear : StInit;

   // Sequencer FSM with registered line_id / draw_start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         line_id_q    <= '0;
         draw_start_q <= 1'b0;
         cx_q         <= '0;
         cy_q         <= '0;
         frame_cnt_q  <= '0;
         lat_cnt_q    <= '0;
      end else begin
         draw_start_q <= 1'b0;
         case (state_q)
            StIdle: begin
               line_id_q   <= '0;
               cx_q        <= '0;
               cy_q        <= '0;
               frame_cnt_q <= '0;
               lat_cnt_q   <= '0;
               if (enable && frame) begin
                  state_q <= start_state;
               end
            end

            StClear: begin
               if (!enable) begin
                  state_q <= StIdle;
                  cx_q    <= '0;
                  cy_q    <= '0;
               end else if (cx_q == CX_LAST) begin
                  cx_q <= '0;
                  if (cy_q == CY_LAST) begin
                     cy_q    <= '0;
                     state_q <= StInit;
                  end else begin
                     cy_q <= cy_q + CYW'(1);
                  end
               end else begin
                  cx_q <= cx_q + CXW'(1);
               end
            end

            // Give the geometry source GEOM_LAT cycles to settle on the new line_id.
            StInit: begin
               if (!enable) begin
                  state_q   <= StIdle;
                  lat_cnt_q <= '0;
                  line_id_q <= '0;
               end else if (lat_cnt_q == LAT_LAST) begin
                  lat_cnt_q    <= '0;
                  draw_start_q <= 1'b1;
                  state_q      <= StDraw;
               end else begin
                  lat_cnt_q <= lat_cnt_q + LATW'(1);
               end
            end

            // A line in flight always completes; abort is only honoured at draw_done.
            StDraw: begin
               if (draw_done) begin
                  if (!enable) begin
                     state_q   <= StIdle;
                     line_id_q <= '0;
                  end else if (line_id_q == LINE_LAST) begin
                     state_q   <= StDone;
                     line_id_q <= '0;
                  end else begin
                     line_id_q <= line_id_q + LINEW'(1);
                     state_q   <= StInit;
                  end
               end
            end

            StDone: begin
               if (!enable) begin
                  state_q     <= StIdle;
                  frame_cnt_q <= '0;
               end else if (!mode) begin
                  frame_cnt_q <= '0;
               end else if (frame) begin
                  if (frame_cnt_q == FC_LAST) begin
                     frame_cnt_q <= '0;
                     state_q     <= start_state;
                  end else begin
                     frame_cnt_q <= frame_cnt_q + FCW'(1);
                  end
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign line_id    = line_id_q;
   assign draw_start = draw_start_q;

   // Framebuffer port steering and status decode.
   always_comb begin
      fb_we    = 1'b0;
      fb_x     = sx;
      fb_y     = sy;
      fb_color = '0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         StClear: begin
            fb_we    = 1'b1;
            fb_x     = XY_BITW'(cx_q);
            fb_y     = XY_BITW'(cy_q);
            fb_color = BG;
            busy     = 1'b1;
         end
         StInit: begin
            busy = 1'b1;
         end
         StDraw: begin
            fb_we    = drawing;
            fb_x     = dl_x;
            fb_y     = dl_y;
            fb_color = line_color;
            busy     = 1'b1;
         end
         StDone: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: three instances (clear + GEOM_LAT 1, no clear with GEOM_LAT 0 and 3),
// each driven by a stub rasteriser; framebuffer writes of instance 0 are scoreboarded.
module tb_draw_sequencer;

   localparam int unsigned XYW = 16;
   localparam int unsigned CW  = 3;
   localparam int unsigned LW  = 2;
   localparam int unsigned N   = 3;
   localparam int unsigned LAT_TAB [N] = '{1, 0, 3};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic           en [N], md [N], fr [N], drw [N], ddn [N], inj [N];
   logic           ds [N], we [N], bsy [N], dn [N];
   logic [XYW-1:0] dlx [N], dly [N], fx [N], fy [N];
   logic [CW-1:0]  lc [N], fc [N];
   logic [LW-1:0]  lid [N];
   logic [XYW-1:0] sx, sy;

   for (genvar g = 0; g < N; g++) begin : g_dut
      draw_sequencer #(
         .XY_BITW      (XYW),
         .LINE_CNT     (3),
         .COLORW       (CW),
         .FB_WIDTH     (4),
         .FB_HEIGHT    (3),
         .CLEAR_EN     ((g == 0) ? 1 : 0),
         .BG_COLOR     (5),
         .GEOM_LAT     (LAT_TAB[g]),
         .REDRAW_FRAMES(2)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .enable    (en[g]),
         .mode      (md[g]),
         .frame     (fr[g]),
         .line_id   (lid[g]),
         .line_color(lc[g]),
         .draw_start(ds[g]),
         .drawing   (drw[g]),
         .draw_done (ddn[g]),
         .dl_x      (dlx[g]),
         .dl_y      (dly[g]),
         .sx        (sx),
         .sy        (sy),
         .fb_we     (we[g]),
         .fb_x      (fx[g]),
         .fb_y      (fy[g]),
         .fb_color  (fc[g]),
         .busy      (bsy[g]),
         .done      (dn[g])
      );
   end

   // Geometry source: colour of line n is n+2.
   always_comb begin
      for (int i = 0; i < N; i++) lc[i] = 3'(lid[i]) + 3'd2;
   end

   int             vectors = 0;
   int             miscompares = 0;
   logic [34:0]    exp_q [$];
   int unsigned    cnt [N], sline [N], pix [N];
   int unsigned    cyc = 0, wrcnt = 0;
   int unsigned    chg [N], dscnt [N];
   logic           pds [N], pbsy [N];
   logic [LW-1:0]  plid [N];

   // Stub rasteriser: 4 drawing cycles after draw_start, draw_done on the last one.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            cnt[i] = 0; sline[i] = 0; pix[i] = 0;
            drw[i] = 1'b0; ddn[i] = 1'b0; dlx[i] = '0; dly[i] = '0;
         end else begin
            if (cnt[i] > 0) begin
               drw[i] = 1'b1;
               dlx[i] = XYW'(pix[i]);
               dly[i] = XYW'(sline[i]);
               ddn[i] = (cnt[i] == 1);
               if (i == 0) exp_q.push_back({dlx[i], dly[i], 3'(sline[i] + 2)});
               pix[i]++;
               cnt[i]--;
               if (cnt[i] == 0) sline[i] = (sline[i] == 2) ? 0 : sline[i] + 1;
            end else if (inj[i]) begin
               drw[i] = 1'b1; ddn[i] = 1'b1; dlx[i] = 16'h00ab;
            end else begin
               drw[i] = 1'b0; ddn[i] = 1'b0;
               if (!en[i]) sline[i] = 0;
            end
            if (ds[i]) cnt[i] = 4;
         end
      end
   end

   // Monitor: scoreboard instance 0 writes, check draw_start width and latency on all.
   always @(negedge clk) begin
      logic [34:0] got, expv;
      #1;
      cyc++;
      if (!rst) begin
         if (we[0]) begin
            wrcnt++;
            vectors++;
            got = {fx[0], fy[0], fc[0]};
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL fb_write: got x=%0d y=%0d c=%0d, required no write",
                        fx[0], fy[0], fc[0]);
            end else begin
               expv = exp_q.pop_front();
               if (got !== expv) begin
                  miscompares++;
                  $display("FAIL fb_write: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                           got[34:19], got[18:3], got[2:0], expv[34:19], expv[18:3], expv[2:0]);
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (bsy[i] && !pbsy[i]) chg[i] = cyc + ((i == 0) ? 12 : 0);
            else if (lid[i] !== plid[i]) chg[i] = cyc;
            if (ds[i]) begin
               dscnt[i]++;
               vectors++;
               if (pds[i]) begin
                  miscompares++;
                  $display("FAIL start_width[%0d]: got 2+ cycles, required 1", i);
               end else if (cyc - chg[i] != LAT_TAB[i] + 1) begin
                  miscompares++;
                  $display("FAIL start_latency[%0d]: got %0d, required %0d", i,
                           cyc - chg[i], LAT_TAB[i] + 1);
               end
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         pds[i] = rst ? 1'b0 : ds[i];
         pbsy[i] = rst ? 1'b0 : bsy[i];
         plid[i] = rst ? '0 : lid[i];
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_done(input int i, input int budget);
      int k = 0;
      while (dn[i] !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      vectors++;
      if (dn[i] !== 1'b1) begin
         miscompares++;
         $display("FAIL done_timeout[%0d]: got done=%b after %0d cycles, required 1", i, dn[i], k);
      end
   endtask

   task automatic push_clear();
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 4; x++) exp_q.push_back({16'(x), 16'(y), 3'd5});
   endtask

   task automatic test_reset();
      logic [8:0] got;
      rst = 1'b1;
      sx = 16'd9; sy = 16'd2;
      for (int i = 0; i < N; i++) begin
         en[i] = 1'b1; md[i] = 1'b0; fr[i] = 1'b0; inj[i] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < N; i++) fr[i] = (k != 1);
         tick();
      end
      for (int i = 0; i < N; i++) begin
         got = {bsy[i], dn[i], we[i], ds[i], lid[i], fc[i]};
         vectors++;
         if (got !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_hold[%0d]: got %b, required 0", i, got);
         end
         en[i] = 1'b0; fr[i] = 1'b0;
      end
      rst = 1'b0;
      tick();
      for (int i = 0; i < N; i++) begin
         got = {bsy[i], dn[i], we[i], ds[i], lid[i], fc[i]};
         vectors++;
         if (got !== 9'd0 || fx[i] !== sx || fy[i] !== sy) begin
            miscompares++;
            $display("FAIL reset_idle[%0d]: got flags=%b fb=%0d,%0d, required 0 and %0d,%0d",
                     i, got, fx[i], fy[i], sx, sy);
         end
      end
   endtask

   task automatic test_clear();
      int run = 0;
      logic [4:0] got;
      exp_q.delete();
      push_clear();
      en[0] = 1'b1; md[0] = 1'b0; fr[0] = 1'b1;
      tick();
      fr[0] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (we[0]) run++;
         tick();
      end
      vectors++;
      if (run != 12) begin
         miscompares++;
         $display("FAIL clear_len: got %0d write cycles, required 12", run);
      end
      got = {we[0], bsy[0], ds[0], lid[0]};
      vectors++;
      if (got !== 5'b01000) begin
         miscompares++;
         $display("FAIL clear_to_init: got we,busy,start,id=%b, required 01000", got);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL clear_left: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_one_shot();
      int unsigned ds0 = dscnt[0];
      int unsigned w0 = wrcnt;
      logic [3:0] got;
      wait_done(0, 200);
      vectors++;
      if (dscnt[0] - ds0 != 3 || wrcnt - w0 != 12 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL oneshot_count: got starts=%0d writes=%0d pending=%0d, required 3 12 0",
                  dscnt[0] - ds0, wrcnt - w0, exp_q.size());
      end
      for (int k = 0; k < 6; k++) begin
         sx = XYW'(k + 20);
         fr[0] = (k % 2 == 0);
         tick();
         got = {dn[0], bsy[0], we[0], lid[0] != 0};
         vectors++;
         if (got !== 4'b1000 || fx[0] !== sx) begin
            miscompares++;
            $display("FAIL oneshot_hold: got done,busy,we,id!=0=%b fb_x=%0d, required 1000 %0d",
                     got, fx[0], sx);
         end
      end
      fr[0] = 1'b0; en[0] = 1'b0;
      tick();
      vectors++;
      if ({dn[0], bsy[0]} !== 2'b00) begin
         miscompares++;
         $display("FAIL oneshot_release: got done,busy=%b, required 00", {dn[0], bsy[0]});
      end
   endtask

   task automatic test_continuous();
      int unsigned ds0;
      logic [4:0] got;
      md[0] = 1'b1; en[0] = 1'b1;
      push_clear();
      fr[0] = 1'b1;
      tick();
      fr[0] = 1'b0;
      wait_done(0, 300);
      repeat (3) tick();
      fr[0] = 1'b1;
      tick();
      fr[0] = 1'b0;
      repeat (4) begin
         tick();
         vectors++;
         if ({dn[0], bsy[0], we[0]} !== 3'b100) begin
            miscompares++;
            $display("FAIL cont_first_pulse: got done,busy,we=%b, required 100",
                     {dn[0], bsy[0], we[0]});
         end
      end
      push_clear();
      ds0 = dscnt[0];
      fr[0] = 1'b1;
      tick();
      fr[0] = 1'b0;
      got = {bsy[0], we[0], lid[0], dn[0]};
      vectors++;
      if (got !== 5'b11000) begin
         miscompares++;
         $display("FAIL cont_restart: got busy,we,id,done=%b, required 11000", got);
      end
      wait_done(0, 300);
      vectors++;
      if (dscnt[0] - ds0 != 3 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL cont_pass: got starts=%0d pending=%0d, required 3 0",
                  dscnt[0] - ds0, exp_q.size());
      end
      md[0] = 1'b0;
      fr[0] = 1'b1;
      tick();
      fr[0] = 1'b0;
      fr[0] = 1'b1;
      tick();
      fr[0] = 1'b0;
      tick();
      vectors++;
      if ({dn[0], bsy[0]} !== 2'b10) begin
         miscompares++;
         $display("FAIL cont_mode_off: got done,busy=%b, required 10", {dn[0], bsy[0]});
      end
      en[0] = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      int unsigned ds0;
      int k = 0;
      push_clear();
      en[0] = 1'b1; md[0] = 1'b0; fr[0] = 1'b1;
      tick();
      fr[0] = 1'b0;
      while (!(lid[0] == 2'd1 && drw[0]) && k < 200) begin
         tick();
         k++;
      end
      vectors++;
      if (!(lid[0] == 2'd1 && drw[0])) begin
         miscompares++;
         $display("FAIL abort_reach: got line_id=%0d, required 1 while drawing", lid[0]);
      end
      en[0] = 1'b0;
      ds0 = dscnt[0];
      k = 0;
      while (bsy[0] && k < 50) begin
         tick();
         k++;
      end
      repeat (10) tick();
      vectors++;
      if ({bsy[0], dn[0]} !== 2'b00 || lid[0] !== 2'd0 || dscnt[0] != ds0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL abort_draw: got busy,done=%b id=%0d starts=+%0d pending=%0d, required 00 0 +0 0",
                  {bsy[0], dn[0]}, lid[0], dscnt[0] - ds0, exp_q.size());
      end
      push_clear();
      en[0] = 1'b1; fr[0] = 1'b1;
      tick();
      fr[0] = 1'b0;
      tick();
      tick();
      en[0] = 1'b0;
      tick();
      vectors++;
      if ({bsy[0], we[0]} !== 2'b00 || exp_q.size() != 9) begin
         miscompares++;
         $display("FAIL abort_clear: got busy,we=%b pending=%0d, required 00 9",
                  {bsy[0], we[0]}, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_stray();
      inj[0] = 1'b1;
      tick();
      inj[0] = 1'b0;
      vectors++;
      if ({we[0], bsy[0]} !== 2'b00) begin
         miscompares++;
         $display("FAIL stray_done_write: got we,busy=%b, required 00", {we[0], bsy[0]});
      end
      tick();
      fr[0] = 1'b1;
      vectors++;
      if ({bsy[0], dn[0], lid[0]} !== 4'b0000) begin
         miscompares++;
         $display("FAIL stray_done_state: got busy,done,id=%b, required 0000",
                  {bsy[0], dn[0], lid[0]});
      end
      tick();
      fr[0] = 1'b0;
      tick();
      vectors++;
      if (bsy[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL stray_frame: got busy=%b, required 0", bsy[0]);
      end
   endtask

   task automatic test_latency();
      int unsigned d1 = dscnt[1];
      int unsigned d2 = dscnt[2];
      for (int i = 1; i < N; i++) begin
         en[i] = 1'b1; md[i] = 1'b0; fr[i] = 1'b1;
      end
      tick();
      for (int i = 1; i < N; i++) fr[i] = 1'b0;
      wait_done(1, 200);
      wait_done(2, 200);
      vectors++;
      if (dscnt[1] - d1 != 3 || dscnt[2] - d2 != 3) begin
         miscompares++;
         $display("FAIL latency_starts: got %0d and %0d, required 3 and 3",
                  dscnt[1] - d1, dscnt[2] - d2);
      end
      for (int i = 1; i < N; i++) en[i] = 1'b0;
      tick();
      vectors++;
      if ({bsy[1], dn[1], bsy[2], dn[2]} !== 4'b0000) begin
         miscompares++;
         $display("FAIL latency_release: got %b, required 0000", {bsy[1], dn[1], bsy[2], dn[2]});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_clear();
      test_one_shot();
      test_continuous();
      test_abort();
      test_stray();
      test_latency();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL final_pending: got %0d, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
